// File: rtl/ps2_pkg.sv
// ps2_pkg: shared decoder state type and PS/2 set-2 control byte constants
package ps2_pkg;
  typedef enum logic [1:0] {IDLE, BREAK, EXT, EXT_BREAK} ps2_state_t;
  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_SPACE  = 8'h29;
  localparam logic [7:0] SC_BAT    = 8'hAA;
  localparam logic [7:0] SC_ACK    = 8'hFA;
  localparam logic [7:0] SC_ECHO   = 8'hEE;
  localparam logic [7:0] SC_RESEND = 8'hFE;
endpackage

// File: rtl/ps2_set2_to_ascii.sv
// ps2_set2_to_ascii: combinational set-2 make code to lowercase ASCII lookup
module ps2_set2_to_ascii
  import ps2_pkg::*;
#(
  parameter bit EMIT_SPACE = 1'b1
) (
  input  logic [7:0] code,
  output logic [7:0] ascii,
  output logic       hit
);
  always_comb begin
    ascii = 8'd0;
    hit   = 1'b1;
    case (code)
      8'h1C: ascii = "a";
      8'h32: ascii = "b";
      8'h21: ascii = "c";
      8'h23: ascii = "d";
      8'h24: ascii = "e";
      8'h2B: ascii = "f";
      8'h34: ascii = "g";
      8'h33: ascii = "h";
      8'h43: ascii = "i";
      8'h3B: ascii = "j";
      8'h42: ascii = "k";
      8'h4B: ascii = "l";
      8'h3A: ascii = "m";
      8'h31: ascii = "n";
      8'h44: ascii = "o";
      8'h4D: ascii = "p";
      8'h15: ascii = "q";
      8'h2D: ascii = "r";
      8'h1B: ascii = "s";
      8'h2C: ascii = "t";
      8'h3C: ascii = "u";
      8'h2A: ascii = "v";
      8'h1D: ascii = "w";
      8'h22: ascii = "x";
      8'h35: ascii = "y";
      8'h1A: ascii = "z";
      SC_SPACE: begin
        ascii = 8'd32;
        hit   = EMIT_SPACE;
      end
      default: hit = 1'b0;
    endcase
  end
endmodule

// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder: PS/2 set-2 byte stream to one-cycle ASCII/Enter strobes
// Tracks F0/E0 prefixes and the last held key for typematic suppression.
module ps2_scancode_decoder
  import ps2_pkg::*;
#(
  parameter bit SUPPRESS_REPEAT = 1'b1,
  parameter bit EMIT_SPACE      = 1'b1
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] scan_code,
  input  logic       scan_valid,
  output logic [7:0] char_out,
  output logic       char_valid,
  output logic       enter_pulse,
  output logic       busy
);
  ps2_state_t r_state, w_state_nxt;
  logic [7:0] r_held, w_held_nxt, w_char_nxt, w_ascii;
  logic       w_hit, w_cv_nxt, w_ep_nxt, w_ignored;

  ps2_set2_to_ascii #(.EMIT_SPACE(EMIT_SPACE)) u_lut (
    .code (scan_code),
    .ascii(w_ascii),
    .hit  (w_hit)
  );

  // Controller replies and idle bytes that never count as key makes
  assign w_ignored = scan_code inside {SC_BAT, SC_ACK, SC_ECHO, SC_RESEND, 8'h00, 8'hFF};

  always_comb begin
    w_state_nxt = r_state;
    w_held_nxt  = r_held;
    w_char_nxt  = char_out;
    w_cv_nxt    = 1'b0;
    w_ep_nxt    = 1'b0;
    if (scan_valid) begin
      case (r_state)
        IDLE: begin
          if (scan_code == SC_BREAK) w_state_nxt = BREAK;
          else if (scan_code == SC_EXT) w_state_nxt = EXT;
          else if (!w_ignored && !(SUPPRESS_REPEAT && scan_code == r_held)) begin
            if (w_hit) begin
              w_char_nxt = w_ascii;
              w_cv_nxt   = 1'b1;
              w_held_nxt = scan_code;
            end else if (scan_code == SC_ENTER) begin
              w_ep_nxt   = 1'b1;
              w_held_nxt = scan_code;
            end
          end
        end
        BREAK: begin
          w_state_nxt = IDLE;
          w_held_nxt  = (scan_code == r_held) ? 8'h00 : r_held;
        end
        EXT:     w_state_nxt = (scan_code == SC_BREAK) ? EXT_BREAK : IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= IDLE;
      r_held      <= 8'h00;
      char_out    <= 8'd32;
      char_valid  <= 1'b0;
      enter_pulse <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_held      <= w_held_nxt;
      char_out    <= w_char_nxt;
      char_valid  <= w_cv_nxt;
      enter_pulse <= w_ep_nxt;
    end
  end

  assign busy = (r_state != IDLE);
endmodule
